fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer side of the jump/branch redirect interface: owns the architectural PC and fetches RV32I instructions from instruction memory.
- Accepts PC redirects (update-control, target value) from the jump/branch units and squashes wrong-path instructions itself.
- Sits between instruction memory and decode.
- Presents in-order (instruction, pc) pairs to decode through a 2-entry buffer with a valid/ready handshake.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
BUF_DEPTH, 2, instruction buffer entries; fixed at 2 for this revision.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  reset; asynchronous, active-high.
i_redirect  input  1  PC update control from jump/branch units; single-cycle pulse.
i_redirect_pc  input  32  PC update value.
o_imem_req  output  1  fetch request valid.
o_imem_addr  output  32  fetch byte address, word aligned.
i_imem_gnt  input  1  memory accepts request this cycle.
i_imem_rvalid  input  1  read data valid; responses in request order.
i_imem_rdata  input  32  instruction word.
o_inst_valid  output  1  buffer head valid to decode.
o_inst  output  32  buffer head instruction.
o_inst_pc  output  32  PC of buffer head.
i_dec_ready  input  1  decode consumes head when high with o_inst_valid.
o_flush  output  1  registered pulse: wrong-path state discarded last cycle.
o_fetch_misaligned  output  1  sticky: redirect target not 4-byte aligned.

Behaviour:
- Reset (async, i_rst=1):
  - pc=RESET_PC; buffer empty; state RUN.
  - o_imem_req=0, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_flush=0, o_fetch_misaligned=0.
- State machine:
  - RUN: no request outstanding.
  - WAIT: one granted request outstanding.
  - DROP: one outstanding request whose response must be discarded.
  - HALT: misaligned target received.
- Request issue:
  - o_imem_req=1 in RUN or WAIT when (buffer count + outstanding) < 2 and i_redirect=0.
  - Max one outstanding granted request; a new request may be granted in the same cycle the outstanding response returns.
  - o_imem_addr=pc held stable while req=1 and gnt=0.
  - On gnt: pc <= pc+4 (mod 2^32, wraps); RUN->WAIT.
- Response:
  - In WAIT, rvalid writes {rdata, addr-of-request} into the buffer tail.
  - Goes ->RUN unless a new grant occurs the same cycle.
  - Buffer cannot overflow by the issue rule; rvalid in RUN is a protocol error (assertion).
- Decode handshake:
  - Head popped when o_inst_valid & i_dec_ready.
  - Push and pop in the same cycle are allowed at any count.
  - o_inst/o_inst_pc hold while valid and not ready.
- Redirect (i_redirect=1), all effective in the same cycle:
  - Buffer flushed; o_inst_valid=0 next cycle; no pop counted.
  - o_imem_req forced 0; an ungranted request is abandoned.
  - pc <= {i_redirect_pc[31:1],1'b0} (JALR LSB clear).
  - If a request is outstanding and rvalid is not asserted this cycle: ->DROP. If rvalid is asserted this cycle: data discarded, ->RUN.
  - o_flush=1 next cycle for one cycle.
- DROP:
  - No requests issued.
  - Next rvalid discarded -> RUN.
  - A further redirect in DROP updates pc only and stays in DROP.
- Misalignment:
  - Redirect with i_redirect_pc[1]=1: ->HALT, o_fetch_misaligned=1.
  - No further requests; any pending response is discarded.
  - Leave HALT only by reset.
- Simultaneous events: a redirect wins over gnt, rvalid push, and pop in the same cycle.
- First fetch after reset: o_imem_req=1 in the cycle after i_rst deasserts.
- Redirect-to-request latency: new target on o_imem_addr the cycle after the redirect (RUN), or the cycle after the dropped rvalid (DROP).

Test Plan:
- Reset with RESET_PC=0x100, gnt always 1, rvalid 1 cycle after gnt, dec_ready=1 -> addrs 0x100,0x104,0x108 on consecutive grants; o_inst_pc follows the same sequence; no gaps after the first fill.
- dec_ready=0 for 6 cycles -> exactly 2 entries buffered, o_imem_req=0, head 0x100 stable; then ready=1 drains 0x100,0x104 in order with no loss.
- Redirect to 0x2000 while a request for 0x108 is outstanding -> o_flush pulse, the 0x108 response is dropped, next o_imem_addr=0x2000, and the first o_inst_pc after the redirect is 0x2000.
- Redirect to 0x3001 and rvalid in the same cycle -> data discarded, next fetch 0x3000, o_fetch_misaligned=0.
- Redirect to 0x4002 -> o_fetch_misaligned=1, o_imem_req stays 0 for 20 cycles, o_inst_valid=0; reset clears the fault.
- PC=0xFFFF_FFFC granted -> next fetch addr 0x0000_0000; i_rst asserted mid-WAIT -> all outputs zero immediately, and the late rvalid after reset is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues in-order word fetches, squashes wrong-path
// responses on jump/branch redirects and feeds decode through a 2-entry buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_dec_ready,
  output logic        o_flush,
  output logic        o_fetch_misaligned
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t          slot0_q, slot0_d;
  entry_t          slot1_q, slot1_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;

  logic            req_c;
  logic            grant_c;
  logic            push_c;
  logic            pop_c;
  logic [OCC_W-1:0] occ_after_c;
  entry_t          new_entry_c;
  logic [XLEN-1:0] target_c;
  logic            unused_target_lsb;

  assign unused_target_lsb = i_redirect_pc[0];
  assign target_c          = {i_redirect_pc[XLEN-1:1], 1'b0};
  assign new_entry_c       = '{inst: i_imem_rdata, pc: req_pc_q};

  // Occupancy once this cycle's response and decode pop have settled; a request
  // may then be issued if a slot is guaranteed for its response.
  always_comb begin
    push_c      = (state_q == S_WAIT) && i_imem_rvalid;
    pop_c       = (count_q != '0) && i_dec_ready;
    occ_after_c = OCC_W'(count_q) + OCC_W'(push_c) - OCC_W'(pop_c);
    req_c       = !i_rst && !i_redirect
                  && ((state_q == S_RUN) || ((state_q == S_WAIT) && i_imem_rvalid))
                  && (occ_after_c < OCC_W'(BUF_DEPTH));
    grant_c     = req_c && i_imem_gnt;
  end

  // Next-state, PC and buffer update; a redirect overrides grant, push and pop.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    flush_d  = i_redirect;
    mis_d    = mis_q;

    if (i_redirect) begin
      count_d = '0;
      pc_d    = target_c;
      if (i_redirect_pc[1]) begin
        mis_d   = 1'b1;
        state_d = S_HALT;
      end else if (state_q == S_HALT) begin
        state_d = S_HALT;
      end else if ((state_q == S_RUN) || i_imem_rvalid) begin
        state_d = S_RUN;
      end else begin
        state_d = S_DROP;
      end
    end else begin
      unique case ({push_c, pop_c})
        2'b10: begin
          if (count_q == '0) slot0_d = new_entry_c;
          else               slot1_d = new_entry_c;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            slot0_d = new_entry_c;
          end else begin
            slot0_d = slot1_q;
            slot1_d = new_entry_c;
          end
        end
        default: ;
      endcase

      unique case (state_q)
        S_RUN:   if (grant_c) state_d = S_WAIT;
        S_WAIT:  if (i_imem_rvalid) state_d = grant_c ? S_WAIT : S_RUN;
        S_DROP:  if (i_imem_rvalid) state_d = S_RUN;
        default: state_d = S_HALT;
      endcase

      if (grant_c) begin
        pc_d     = pc_q + XLEN'(4);
        req_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= '0;
      slot0_q  <= '0;
      slot1_q  <= '0;
      flush_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      flush_q  <= flush_d;
      mis_q    <= mis_d;
    end
  end

  assign o_imem_req         = req_c;
  assign o_imem_addr        = pc_q;
  assign o_inst_valid       = (count_q != '0);
  assign o_inst             = slot0_q.inst;
  assign o_inst_pc          = slot0_q.pc;
  assign o_flush            = flush_q;
  assign o_fetch_misaligned = mis_q;

  // A response can only follow a granted request.
  a_no_rvalid_in_run: assert property (@(posedge i_clk) disable iff (i_rst)
    !((state_q == S_RUN) && i_imem_rvalid));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit plus hand-written halt and drop sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        flush;
  logic        fetch_misaligned;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_redirect         (redirect),
    .i_redirect_pc      (redirect_pc),
    .o_imem_req         (imem_req),
    .o_imem_addr        (imem_addr),
    .i_imem_gnt         (imem_gnt),
    .i_imem_rvalid      (imem_rvalid),
    .i_imem_rdata       (imem_rdata),
    .o_inst_valid       (inst_valid),
    .o_inst             (inst),
    .o_inst_pc          (inst_pc),
    .i_dec_ready        (dec_ready),
    .o_flush            (flush),
    .o_fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          rdr;
    logic [31:0] rpc;
    bit          gnt;
    bit          rv;
    logic [31:0] rd;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_val;
    bit          chk_d;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    bit          e_flush;
    bit          e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, bit rdr, logic [31:0] rpc, bit gnt, bit rv, logic [31:0] rd,
                             bit rdy, bit req, logic [31:0] addr, bit val, bit chk,
                             logic [31:0] ins, logic [31:0] ipc, bit fl, bit mis);
    vec_t x;
    x.rst = r; x.rdr = rdr; x.rpc = rpc; x.gnt = gnt; x.rv = rv; x.rd = rd; x.rdy = rdy;
    x.e_req = req; x.e_addr = addr; x.e_val = val; x.chk_d = chk;
    x.e_inst = ins; x.e_ipc = ipc; x.e_flush = fl; x.e_mis = mis;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit rdr, input logic [31:0] rpc, input bit gnt,
                       input bit rv, input logic [31:0] rd, input bit rdy);
    rst         = r;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rd;
    dec_ready   = rdy;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    // rst rdr rpc gnt rv rdata rdy | req addr val chk inst ipc flush mis
    vecs.push_back(v(1,0,0,0,0,0,1,                         0,0,0,1,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0,1,                         1,32'h100,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,1,32'h1000_0100,1,             1,32'h104,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,1,32'h1000_0104,1,             1,32'h108,1,1,32'h1000_0100,32'h100,0,0));
    vecs.push_back(v(0,0,0,1,1,32'h1000_0108,1,             1,32'h10C,1,1,32'h1000_0104,32'h104,0,0));
    vecs.push_back(v(0,0,0,1,1,32'h1000_010C,0,             0,0,1,1,32'h1000_0108,32'h108,0,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(v(0,0,0,1,0,0,0,                       0,0,1,1,32'h1000_0108,32'h108,0,0));
    vecs.push_back(v(0,0,0,1,0,0,1,                         1,32'h110,1,1,32'h1000_0108,32'h108,0,0));
    vecs.push_back(v(0,0,0,1,1,32'h1000_0110,1,             1,32'h114,1,1,32'h1000_010C,32'h10C,0,0));
    vecs.push_back(v(0,1,32'h2000,1,0,0,1,                  0,0,1,1,32'h1000_0110,32'h110,0,0));
    vecs.push_back(v(0,0,0,1,0,0,1,                         0,0,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,1,1,32'h1000_0114,1,             0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0,1,                         1,32'h2000,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,32'h1000_2000,1,             1,32'h2004,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,                         1,32'h2004,1,1,32'h1000_2000,32'h2000,0,0));
    vecs.push_back(v(0,0,0,1,0,0,0,                         1,32'h2004,1,1,32'h1000_2000,32'h2000,0,0));
    vecs.push_back(v(0,1,32'h3001,1,1,32'h1000_2004,1,      0,0,1,1,32'h1000_2000,32'h2000,0,0));
    vecs.push_back(v(0,0,0,1,0,0,1,                         1,32'h3000,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,0,1,32'h1000_3000,1,             1,32'h3004,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,1,                         1,32'h3004,1,1,32'h1000_3000,32'h3000,0,0));
    vecs.push_back(v(0,1,32'hFFFF_FFFC,1,0,0,1,             0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0,1,                         1,32'hFFFF_FFFC,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,1,1,32'h0FFF_FFFC,1,             1,32'h0000_0000,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,                         0,0,1,1,32'h0FFF_FFFC,32'hFFFF_FFFC,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,                         0,0,0,1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,1,32'h0000_0BAD,0,             0,0,0,1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,1,                         1,32'h100,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0,1,                         1,32'h100,0,0,0,0,0,0));
    vecs.push_back(v(0,1,32'h4002,1,0,0,1,                  0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,1,32'h1000_0100,1,             0,0,0,0,0,0,1,1));
    vecs.push_back(v(0,0,0,1,0,0,1,                         0,0,0,0,0,0,0,1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].rdr, vecs[i].rpc, vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rdy);
      #1;
      chk($sformatf("r%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        chk($sformatf("r%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("r%0d_valid", i), 32'(inst_valid), 32'(vecs[i].e_val));
      if (vecs[i].chk_d) begin
        chk($sformatf("r%0d_inst", i), inst, vecs[i].e_inst);
        chk($sformatf("r%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
      end
      chk($sformatf("r%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("r%0d_misaligned", i), 32'(fetch_misaligned), 32'(vecs[i].e_mis));
    end

    // Halted after a misaligned target: no fetches, nothing to decode, fault held.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, 1);
      #1;
      chk($sformatf("halt%0d_req_val_mis", k), {29'd0, imem_req, inst_valid, fetch_misaligned}, 32'b001);
    end

    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("halt_reset_clears_mis", 32'(fetch_misaligned), 32'd0);

    // Redirect, then a second redirect while the stale response is still pending.
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 1);
    #1;
    chk("drop_first_req", {31'd0, imem_req}, 32'd1);
    chk("drop_first_addr", imem_addr, 32'h100);
    @(negedge clk);
    drive(0, 1, 32'h5000, 1, 0, 0, 1);
    #1;
    chk("drop_rdr1_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    drive(0, 1, 32'h6000, 1, 0, 0, 1);
    #1;
    chk("drop_rdr2_req", 32'(imem_req), 32'd0);
    chk("drop_rdr2_flush", 32'(flush), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 1);
    #1;
    chk("drop_wait_req", 32'(imem_req), 32'd0);
    chk("drop_wait_flush", 32'(flush), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 32'h1000_0100, 1);
    #1;
    chk("drop_rvalid_req", 32'(imem_req), 32'd0);
    chk("drop_rvalid_flush", 32'(flush), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 1);
    #1;
    chk("drop_resume_req", 32'(imem_req), 32'd1);
    chk("drop_resume_addr", imem_addr, 32'h6000);
    chk("drop_resume_valid", 32'(inst_valid), 32'd0);
    chk("drop_resume_mis", 32'(fetch_misaligned), 32'd0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
